// File: rtl/count_stream_checker_pkg.sv
// Shared types and helpers for the count stream checker: FSM state encoding,
// default widths and a saturating increment.
package count_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_LOCK_LEN = 4;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_PASS_MIN = 25;

    // Counters up to SAT_W bits share one increment helper.
    localparam int SAT_W = 32;

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                 input logic [SAT_W-1:0] max);
        return (v >= max) ? v : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/count_stream_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter
    import count_chk_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value
);

    localparam logic [CNT_W-1:0] MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= '0;
        else if (clr)
            value <= '0;
        else if (inc)
            value <= CNT_W'(sat_inc(SAT_W'(value), SAT_W'(MAX)));
    end

endmodule

// File: rtl/count_stream_checker.sv
// Receive-side checker for a free-running counter stream: locks on an
// incrementing sequence, counts matches/errors and flags pass.
// Optional simulation reporting: define COUNT_STREAM_CHECKER_DISPLAY_EN.
module count_stream_checker
    import count_chk_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_LEN = DEF_LOCK_LEN,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int PASS_MIN = DEF_PASS_MIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic             locked,
    output logic             reset_seen,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] match_count,
    output logic [WIDTH-1:0] exp_value,
    output logic [WIDTH-1:0] last_err_exp,
    output logic [WIDTH-1:0] last_err_got,
    output logic             pass
);

    localparam int RUN_W = $clog2(LOCK_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nx;
    logic [RUN_W-1:0] run_len, run_nx;
    logic [WIDTH-1:0] exp_nx, lee_nx, leg_nx;
    logic             reset_seen_nx, err_pulse_nx;
    logic             match_inc, err_inc;
    logic [CNT_W-1:0] match_nx, err_nx;
    logic             pass_nx;

    always_comb begin
        state_nx      = state;
        run_nx        = run_len;
        exp_nx        = exp_value;
        lee_nx        = last_err_exp;
        leg_nx        = last_err_got;
        reset_seen_nx = 1'b0;
        err_pulse_nx  = 1'b0;
        match_inc     = 1'b0;
        err_inc       = 1'b0;
        if (clear) begin
            state_nx = IDLE;
            run_nx   = '0;
            exp_nx   = '0;
            lee_nx   = '0;
            leg_nx   = '0;
        end else if (sample_valid) begin
            // Every accepted sample re-seeds the expectation, match or not.
            exp_nx = sample + WIDTH'(1);
            case (state)
                IDLE: begin
                    run_nx   = RUN_W'(1);
                    state_nx = ACQ;
                end
                ACQ: begin
                    if (sample == exp_value) begin
                        run_nx = run_len + RUN_W'(1);
                        if (run_nx == RUN_W'(LOCK_LEN))
                            state_nx = LOCK;
                    end else begin
                        run_nx = RUN_W'(1);
                    end
                end
                LOCK: begin
                    if (sample == exp_value) begin
                        match_inc = 1'b1;
                    end else if (sample == '0) begin
                        // Upstream counter restarted: not an error, reacquire.
                        reset_seen_nx = 1'b1;
                        run_nx        = RUN_W'(1);
                        state_nx      = ACQ;
                    end else begin
                        err_pulse_nx = 1'b1;
                        err_inc      = 1'b1;
                        lee_nx       = exp_value;
                        leg_nx       = sample;
                    end
                end
                default: begin
                    run_nx   = '0;
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // Next counter values feed pass so it tracks the same edge as the counters.
    always_comb begin
        match_nx = clear ? '0 : match_count;
        err_nx   = clear ? '0 : err_count;
        if (match_inc)
            match_nx = CNT_W'(sat_inc(SAT_W'(match_count), SAT_W'(CNT_MAX)));
        if (err_inc)
            err_nx = CNT_W'(sat_inc(SAT_W'(err_count), SAT_W'(CNT_MAX)));
        pass_nx = (state_nx == LOCK) && (match_nx >= CNT_W'(PASS_MIN)) && (err_nx == '0);
    end

    sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (match_inc),
        .clr   (clear),
        .value (match_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .clr   (clear),
        .value (err_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            run_len      <= '0;
            exp_value    <= '0;
            last_err_exp <= '0;
            last_err_got <= '0;
            locked       <= 1'b0;
            reset_seen   <= 1'b0;
            err_pulse    <= 1'b0;
            pass         <= 1'b0;
        end else begin
            state        <= state_nx;
            run_len      <= run_nx;
            exp_value    <= exp_nx;
            last_err_exp <= lee_nx;
            last_err_got <= leg_nx;
            locked       <= (state_nx == LOCK);
            reset_seen   <= reset_seen_nx;
            err_pulse    <= err_pulse_nx;
            pass         <= pass_nx;
        end
    end

`ifdef COUNT_STREAM_CHECKER_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (err_pulse_nx)
                $display("%0t count_stream_checker: error exp=%0d got=%0d", $time, exp_value, sample);
            if (state_nx == LOCK && state != LOCK)
                $display("%0t count_stream_checker: locked", $time);
            if (reset_seen_nx)
                $display("%0t count_stream_checker: counter reset seen", $time);
        end
    end

    final
        $display("count_stream_checker: match_count=%0d err_count=%0d pass=%0d",
                 match_count, err_count, pass);
`else
    // Reporting disabled: port behaviour is identical either way.
`endif

endmodule
